// File: rtl/game_pkg.sv
// game_pkg: shared constants for the pipe game play sequencer, score counter,
// collision detector and pipe generators.
package game_pkg;

   // Sequencer state encoding, also driven onto the debug/LED state output
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_PLAY  = 2'b01;
   localparam logic [1:0] ST_DYING = 2'b10;
   localparam logic [1:0] ST_OVER  = 2'b11;

   // Two BCD digits
   localparam int unsigned SCORE_W = 8;

   // Frame ticks spent in the death animation
   localparam int unsigned DEATH_FRAMES_DEF = 90;

   // Column the box lives in; pipes crossing it score a point
   localparam int unsigned BOX_COL = 4;

   // Two-digit BCD increment; 99 rolls to 00 (callers saturate before that)
   function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
      logic [3:0] lo;
      logic [3:0] hi;
      lo = v[3:0];
      hi = v[7:4];
      if (lo == 4'd9) begin
         lo = 4'd0;
         hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
      end else begin
         lo = lo + 4'd1;
      end
      return {hi, lo};
   endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: two-digit BCD score register with synchronous clear,
// increment enable and saturation at SCORE_MAX.
module bcd_score_counter
   import game_pkg::*;
#(
   parameter logic [SCORE_W-1:0] SCORE_MAX = 8'h99
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               inc_i,
   output logic [SCORE_W-1:0] score_o
);

   logic [SCORE_W-1:0] score_q, score_d;

   // Clear has priority; increments stop once the ceiling is reached
   always_comb begin
      score_d = score_q;
      if (clr_i) begin
         score_d = '0;
      end else if (inc_i && (score_q != SCORE_MAX)) begin
         score_d = bcd_inc(score_q);
      end
   end

   // Score register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score_o = score_q;

endmodule

// File: rtl/game_controller.sv
// game_controller: play sequencer for the pipe game. Gates pipe motion, clears
// the collision detector, keeps BCD score/high score and times the death
// animation. Define GAME_LIVES_EN to add a lives counter and the lives_left port.
module game_controller
   import game_pkg::*;
#(
   parameter int unsigned        DEATH_FRAMES = DEATH_FRAMES_DEF,
   parameter logic [SCORE_W-1:0] SCORE_MAX    = 8'h99,
   parameter int unsigned        LIVES        = 3
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start_key,
   input  logic               collided,
   input  logic               pipe_passed,
   output logic               run,
   output logic               clear_hit,
   output logic               game_over,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
`ifdef GAME_LIVES_EN
   output logic [1:0]         lives_left,
`endif
   output logic [1:0]         state
);

   if ((LIVES < 1) || (LIVES > 3) || (DEATH_FRAMES < 1) || (DEATH_FRAMES > 255))
   begin : g_bad_params
      $error("game_controller: LIVES must be 1..3 and DEATH_FRAMES 1..255");
   end

   localparam logic [7:0] DeathInit = 8'(DEATH_FRAMES);

   logic [1:0]         state_q, state_d;
   logic [7:0]         timer_q, timer_d;
   logic [SCORE_W-1:0] high_q, high_d;
   logic               run_q, clear_hit_q, game_over_q, key_q;
   logic               press, hit, revive, score_clr, score_inc;
   logic [SCORE_W-1:0] score_w;

   assign press = start_key & ~key_q;

`ifdef GAME_LIVES_EN
   localparam logic [1:0] LivesInit = 2'(LIVES);
   logic [1:0] lives_q, lives_d;
   logic [1:0] guard_q, guard_d;
   // After a revive the detector still holds its flag for a few clocks
   assign hit = collided & (guard_q == 2'd0);
`else
   assign hit = collided;
`endif

   // Next-state, timer, high score and lives decisions
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      high_d    = high_q;
      score_clr = 1'b0;
      score_inc = 1'b0;
      revive    = 1'b0;
`ifdef GAME_LIVES_EN
      lives_d   = lives_q;
      guard_d   = guard_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A press while the flag is still set is dropped, not queued
            if (press && !collided) begin
               state_d   = ST_PLAY;
               score_clr = 1'b1;
`ifdef GAME_LIVES_EN
               lives_d   = LivesInit;
`endif
            end
         end
         ST_PLAY: begin
`ifdef GAME_LIVES_EN
            if (guard_q != 2'd0) guard_d = guard_q - 2'd1;
`endif
            if (hit) begin
               state_d = ST_DYING;
               timer_d = DeathInit;
            end else if (pipe_passed) begin
               score_inc = 1'b1;
            end
         end
         ST_DYING: begin
            if (frame_tick) begin
               timer_d = timer_q - 8'd1;
               if (timer_q == 8'd1) begin
`ifdef GAME_LIVES_EN
                  if (lives_q > 2'd1) begin
                     lives_d = lives_q - 2'd1;
                     state_d = ST_PLAY;
                     revive  = 1'b1;
                     guard_d = 2'd3;
                  end else begin
                     lives_d = 2'd0;
                     state_d = ST_OVER;
                     if (score_w > high_q) high_d = score_w;
                  end
`else
                  state_d = ST_OVER;
                  if (score_w > high_q) high_d = score_w;
`endif
               end
            end
         end
         ST_OVER: begin
            if (press) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, timer, high score and registered outputs (derived from next state)
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         timer_q     <= 8'd0;
         high_q      <= '0;
         run_q       <= 1'b0;
         clear_hit_q <= 1'b1;
         game_over_q <= 1'b0;
         key_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         high_q      <= high_d;
         run_q       <= (state_d == ST_PLAY);
         clear_hit_q <= (state_d == ST_IDLE) | revive;
         game_over_q <= (state_d == ST_OVER);
         key_q       <= start_key;
      end
   end

`ifdef GAME_LIVES_EN
   // Lives counter and post-revive collision guard
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         lives_q <= LivesInit;
         guard_q <= 2'd0;
      end else begin
         lives_q <= lives_d;
         guard_q <= guard_d;
      end
   end

   assign lives_left = lives_q;
`endif

   bcd_score_counter #(
      .SCORE_MAX (SCORE_MAX)
   ) u_score (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .clr_i   (score_clr),
      .inc_i   (score_inc),
      .score_o (score_w)
   );

   assign run        = run_q;
   assign clear_hit  = clear_hit_q;
   assign game_over  = game_over_q;
   assign score      = score_w;
   assign high_score = high_q;
   assign state      = state_q;

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed bench for game_controller with DEATH_FRAMES=3.
// Lives checks are compiled in when GAME_LIVES_EN is defined.
module tb_game_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick, start_key, collided, pipe_passed;
   logic       run, clear_hit, game_over;
   logic [7:0] score, high_score;
   logic [1:0] state;
`ifdef GAME_LIVES_EN
   logic [1:0] lives_left;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   game_controller #(
      .DEATH_FRAMES (3)
   ) dut (
      .CLOCK_50    (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start_key   (start_key),
      .collided    (collided),
      .pipe_passed (pipe_passed),
      .run         (run),
      .clear_hit   (clear_hit),
      .game_over   (game_over),
      .score       (score),
      .high_score  (high_score),
`ifdef GAME_LIVES_EN
      .lives_left  (lives_left),
`endif
      .state       (state)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release, then a one-clock key press; returns just after the press edge
   task automatic press_key();
      start_key = 1'b0;
      tick();
      start_key = 1'b1;
      tick();
      start_key = 1'b0;
   endtask

   task automatic pipe_pulse();
      pipe_passed = 1'b1;
      tick();
      pipe_passed = 1'b0;
      tick();
   endtask

   task automatic frame_pulse();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      frame_tick = 1'b0;
      start_key = 1'b0;
      collided = 1'b0;
      pipe_passed = 1'b0;
      #12;
      check("rst_state", {6'd0, state}, 8'h00);
      check("rst_run", {7'd0, run}, 8'h00);
      check("rst_clear_hit", {7'd0, clear_hit}, 8'h01);
      check("rst_game_over", {7'd0, game_over}, 8'h00);
      check("rst_score", score, 8'h00);
      check("rst_high", high_score, 8'h00);
      reset = 1'b0;
      tick();

      // Start, then hold the key
      start_key = 1'b1;
      tick();
      check("start_state", {6'd0, state}, 8'h01);
      check("start_run", {7'd0, run}, 8'h01);
      check("start_clear_hit", {7'd0, clear_hit}, 8'h00);
      check("start_score", score, 8'h00);
      repeat (100) tick();
      check("hold_state", {6'd0, state}, 8'h01);
      start_key = 1'b0;

      // Scoring and saturation
      repeat (12) pipe_pulse();
      check("score_12", score, 8'h12);
      pipe_passed = 1'b1;
      repeat (87) tick();
      check("score_99", score, 8'h99);
      tick();
      check("score_sat", score, 8'h99);

      // Collision wins over a simultaneous pipe pass
      collided = 1'b1;
      tick();
      pipe_passed = 1'b0;
      check("die_state", {6'd0, state}, 8'h02);
      check("die_run", {7'd0, run}, 8'h00);
      check("die_score", score, 8'h99);
      press_key();
      check("dying_press_ignored", {6'd0, state}, 8'h02);
      frame_pulse();
      frame_pulse();
      check("dying_after2", {6'd0, state}, 8'h02);
      frame_pulse();
      check("over_state", {6'd0, state}, 8'h03);
      check("over_game_over", {7'd0, game_over}, 8'h01);
      check("over_high", high_score, 8'h99);

      // OVER -> IDLE, press with flag still set, then a clean start
      press_key();
      check("idle_state", {6'd0, state}, 8'h00);
      check("idle_clear_hit", {7'd0, clear_hit}, 8'h01);
      check("idle_game_over", {7'd0, game_over}, 8'h00);
      press_key();
      check("idle_hit_press", {6'd0, state}, 8'h00);
      collided = 1'b0;
      press_key();
      check("replay_state", {6'd0, state}, 8'h01);
      check("replay_score", score, 8'h00);
      check("replay_high", high_score, 8'h99);

      // Lower score must not replace the high score
      pipe_pulse();
      pipe_pulse();
      check("score_02", score, 8'h02);
      collided = 1'b1;
      tick();
      repeat (3) frame_pulse();
      check("over2_state", {6'd0, state}, 8'h03);
      check("over2_high", high_score, 8'h99);

      // Asynchronous reset mid-death
      press_key();
      collided = 1'b0;
      press_key();
      pipe_pulse();
      collided = 1'b1;
      tick();
      frame_pulse();
      check("pre_rst_state", {6'd0, state}, 8'h02);
      #2;
      reset = 1'b1;
      #1;
      check("arst_state", {6'd0, state}, 8'h00);
      check("arst_run", {7'd0, run}, 8'h00);
      check("arst_score", score, 8'h00);
      check("arst_high", high_score, 8'h00);
      check("arst_clear_hit", {7'd0, clear_hit}, 8'h01);
      collided = 1'b0;
      tick();
      reset = 1'b0;
      tick();

`ifdef GAME_LIVES_EN
      check("lives_rst", {6'd0, lives_left}, 8'h03);
      press_key();
      repeat (5) pipe_pulse();
      check("lives_score", score, 8'h05);
      for (int d = 0; d < 2; d++) begin
         collided = 1'b1;
         tick();
         check("lives_dying", {6'd0, state}, 8'h02);
         repeat (3) frame_pulse();
         check("revive_state", {6'd0, state}, 8'h01);
         check("revive_lives", {6'd0, lives_left}, 8'(2 - d));
         check("revive_clear_hit", {7'd0, clear_hit}, 8'h01);
         check("revive_run", {7'd0, run}, 8'h01);
         check("revive_score", score, 8'h05);
         // Flag still set during the guard window
         repeat (3) tick();
         check("guard_state", {6'd0, state}, 8'h01);
         check("guard_clear_hit", {7'd0, clear_hit}, 8'h00);
         collided = 1'b0;
         tick();
      end
      collided = 1'b1;
      tick();
      repeat (3) frame_pulse();
      check("last_state", {6'd0, state}, 8'h03);
      check("last_lives", {6'd0, lives_left}, 8'h00);
      check("last_high", high_score, 8'h05);
      collided = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
